bist_ctrl: RTL and testbench

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_ctrl.sv | 137 +++++++++++++
 tb/tb_bist_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bist_ctrl
//  Description : Logic-BIST sequencer. It resets the CUT and the MISR, applies
//                NPAT LFSR patterns, waits out the pipeline and then compares
//                the MISR signature against GOLDEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_ctrl #(
    parameter int unsigned     NBIT     = 16,
    parameter int unsigned     NPAT     = 256,
    parameter logic [NBIT-1:0] TPG_SEED = 16'hACE1,
    parameter logic [NBIT-1:0] GOLDEN   = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [NBIT-1:0] signature,
    output logic [3:0]      req_o,
    output logic            cut_rst,
    output logic            misr_rst,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail
);

    localparam int unsigned    CW       = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam logic [CW-1:0]  LAST_PAT = CW'(NPAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [NBIT-1:0] r_lfsr;
    logic [NBIT-1:0] w_lfsr_next;
    logic [CW-1:0]   r_pat_cnt;
    logic            r_settle_cnt;
    logic            r_cut_rst;
    logic            r_misr_rst;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_fail;
    logic            w_match;
    logic            w_next_busy;

    // Fibonacci taps 16/14/13/11 expressed relative to the register width
    assign w_lfsr_next = {r_lfsr[NBIT-2:0],
                          r_lfsr[NBIT-1] ^ r_lfsr[NBIT-3] ^ r_lfsr[NBIT-4] ^ r_lfsr[NBIT-6]};
    assign w_match     = (signature == GOLDEN);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_INIT;
            S_INIT:    w_next_state = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)                       w_next_state = S_IDLE;
                else if (r_pat_cnt == LAST_PAT)  w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)             w_next_state = S_IDLE;
                else if (r_settle_cnt) w_next_state = S_COMPARE;
            end
            S_COMPARE: w_next_state = abort ? S_IDLE : S_DONE;
            S_DONE:    if (start) w_next_state = S_INIT;
            default:   w_next_state = S_IDLE;
        endcase
    end

    assign w_next_busy = (w_next_state == S_INIT) || (w_next_state == S_RUN) ||
                         (w_next_state == S_SETTLE) || (w_next_state == S_COMPARE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= TPG_SEED;
            r_pat_cnt    <= '0;
            r_settle_cnt <= 1'b0;
            r_cut_rst    <= 1'b0;
            r_misr_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cut_rst  <= (w_next_state == S_INIT);
            r_misr_rst <= (w_next_state == S_INIT);
            r_busy     <= w_next_busy;
            r_done     <= (w_next_state == S_DONE);

            case (r_state)
                S_INIT: begin
                    r_lfsr       <= TPG_SEED;
                    r_pat_cnt    <= '0;
                    r_settle_cnt <= 1'b0;
                end
                S_RUN: begin
                    r_lfsr <= w_lfsr_next;
                    // Hold at the last index so the counter never wraps
                    if (r_pat_cnt != LAST_PAT) r_pat_cnt <= r_pat_cnt + CW'(1);
                end
                S_SETTLE:  r_settle_cnt <= ~r_settle_cnt;
                default: ;
            endcase

            // Verdict is latched once on COMPARE exit, held through DONE, cleared otherwise
            if (w_next_state != S_DONE) begin
                r_pass <= 1'b0;
                r_fail <= 1'b0;
            end else if (r_state == S_COMPARE) begin
                r_pass <= w_match;
                r_fail <= ~w_match;
            end
        end
    end

    assign req_o    = (r_state == S_RUN) ? r_lfsr[3:0] : 4'h0;
    assign cut_rst  = r_cut_rst;
    assign misr_rst = r_misr_rst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_ctrl
//  Description : Directed bench for bist_ctrl: a small instance against a
//                signature stub, and a 256-pattern instance driving a
//                round-robin arbiter CUT into a MISR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_ctrl;

    localparam logic [15:0] GOLDEN_A = 16'h5A5A;
    localparam int          NPAT_B   = 256;

    logic        clk;
    logic        rst;
    logic        start_a, abort_a;
    logic [15:0] sig_a;
    logic [3:0]  req_a;
    logic        cut_rst_a, misr_rst_a, busy_a, done_a, pass_a, fail_a;

    logic        start_b;
    logic [3:0]  req_b;
    logic        cut_rst_b, misr_rst_b, busy_b, done_b, pass_b, fail_b;
    logic [3:0]  grant;
    logic [1:0]  ptr;
    logic [15:0] misr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] iv;   // {start, abort, rst, signature error}
        logic [9:0] ev;   // {req_o[3:0], cut_rst, misr_rst, busy, done, pass, fail}
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_pat [4];

    bist_ctrl #(.NBIT(16), .NPAT(4), .TPG_SEED(16'hACE1), .GOLDEN(GOLDEN_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .signature(sig_a),
        .req_o(req_a), .cut_rst(cut_rst_a), .misr_rst(misr_rst_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .fail(fail_a)
    );

    bist_ctrl #(.NBIT(16), .NPAT(NPAT_B), .TPG_SEED(16'hACE1), .GOLDEN(16'h0000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .signature(misr),
        .req_o(req_b), .cut_rst(cut_rst_b), .misr_rst(misr_rst_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail(fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [3:0] g);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {12'h000, g};
    endfunction

    // Returns {next pointer, one-hot grant}; search starts at the pointer
    function automatic logic [5:0] rr_arb(input logic [3:0] rq, input logic [1:0] p);
        logic [3:0] g  = 4'h0;
        logic [1:0] np = p;
        logic [1:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (rq[idx] && (g == 4'h0)) begin
                g[idx] = 1'b1;
                np     = idx + 2'd1;
            end
        end
        return {np, g};
    endfunction

    // Signature seen during COMPARE: N RUN edges plus two SETTLE edges of capture
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] l = 16'hACE1;
        logic [15:0] m = 16'h0000;
        logic [3:0]  g = 4'h0;
        logic [1:0]  p = 2'd0;
        logic [3:0]  rq;
        logic [5:0]  r;
        for (int c = 0; c < n + 2; c++) begin
            m  = misr_step(m, g);
            rq = (c < n) ? l[3:0] : 4'h0;
            if (c < n) l = lfsr_next(l);
            r = rr_arb(rq, p);
            g = r[3:0];
            p = r[5:4];
        end
        return m;
    endfunction

    // Bench-side CUT (1-cycle latency) and MISR for the integrated chain
    always_ff @(posedge clk) begin
        if (rst || cut_rst_b) begin
            grant <= 4'h0;
            ptr   <= 2'd0;
        end else begin
            {ptr, grant} <= rr_arb(req_b, ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || misr_rst_b) misr <= 16'h0000;
        else                   misr <= misr_step(misr, grant);
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] iv, input logic [9:0] ev, input string nm);
        start_a = iv[3];
        abort_a = iv[2];
        rst     = iv[1];
        sig_a   = GOLDEN_A ^ {15'd0, iv[0]};
        @(posedge clk);
        #1;
        check(nm, {6'd0, req_a, cut_rst_a, misr_rst_a, busy_a, done_a, pass_a, fail_a},
              {6'd0, ev});
        check({nm, "_excl"}, {15'd0, pass_a & fail_a}, 16'd0);
    endtask

    task automatic add(input logic [3:0] iv, input logic [9:0] ev, input string nm);
        vec_t v;
        v.iv   = iv;
        v.ev   = ev;
        v.name = nm;
        tbl.push_back(v);
    endtask

    // Full run from IDLE/DONE; hold keeps start high after the first cycle
    task automatic run_seq(input logic hold, input logic err, input string tag);
        step({1'b1, 2'b00, err}, {4'h0, 6'b111000}, {tag, "_init"});
        for (int i = 0; i < 4; i++)
            step({hold, 2'b00, err}, {exp_pat[i], 6'b001000}, $sformatf("%s_pat%0d", tag, i));
        for (int i = 0; i < 3; i++)
            step({hold, 2'b00, err}, {4'h0, 6'b001000}, $sformatf("%s_tail%0d", tag, i));
        step({hold, 2'b00, err}, {4'h0, (err ? 6'b000101 : 6'b000110)}, {tag, "_done"});
    endtask

    task automatic run_chain(output logic [15:0] sig, output int lat);
        logic [15:0] prev;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        lat     = 0;
        prev    = misr;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_b) break;
            prev = misr;
        end
        sig = prev;
    endtask

    initial begin
        logic [15:0] sig1, sig2, ref_sig;
        int          lat1, lat2;

        rst     = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        sig_a   = GOLDEN_A;
        start_b = 1'b0;

        // ACE1 -> 59C3 -> B387 -> 670F under the tap equation
        exp_pat[0] = 4'h1;
        exp_pat[1] = 4'h3;
        exp_pat[2] = 4'h7;
        exp_pat[3] = 4'hF;

        add(4'b0010, {4'h0, 6'b000000}, "reset");
        add(4'b1110, {4'h0, 6'b000000}, "reset_priority");
        add(4'b0000, {4'h0, 6'b000000}, "idle");
        add(4'b0100, {4'h0, 6'b000000}, "idle_abort");
        add(4'b1000, {4'h0, 6'b111000}, "r1_init");
        add(4'b0000, {4'h1, 6'b001000}, "r1_pat0");
        add(4'b0000, {4'h3, 6'b001000}, "r1_pat1");
        add(4'b0000, {4'h7, 6'b001000}, "r1_pat2");
        add(4'b0000, {4'hF, 6'b001000}, "r1_pat3");
        add(4'b0000, {4'h0, 6'b001000}, "r1_settle1");
        add(4'b0000, {4'h0, 6'b001000}, "r1_settle2");
        add(4'b0000, {4'h0, 6'b001000}, "r1_compare");
        add(4'b0000, {4'h0, 6'b000110}, "r1_done_pass");
        add(4'b0100, {4'h0, 6'b000110}, "r1_done_abort");
        add(4'b0000, {4'h0, 6'b000110}, "r1_done_hold");
        add(4'b1001, {4'h0, 6'b111000}, "r2_init");
        add(4'b0001, {4'h1, 6'b001000}, "r2_pat0");
        add(4'b0001, {4'h3, 6'b001000}, "r2_pat1");
        add(4'b0001, {4'h7, 6'b001000}, "r2_pat2");
        add(4'b0001, {4'hF, 6'b001000}, "r2_pat3");
        add(4'b0001, {4'h0, 6'b001000}, "r2_settle1");
        add(4'b0001, {4'h0, 6'b001000}, "r2_settle2");
        add(4'b0001, {4'h0, 6'b001000}, "r2_compare");
        add(4'b0001, {4'h0, 6'b000101}, "r2_done_fail");
        add(4'b0000, {4'h0, 6'b000101}, "r2_fail_hold");
        add(4'b0100, {4'h0, 6'b000101}, "r2_fail_abort");
        add(4'b1100, {4'h0, 6'b111000}, "start_beats_abort");

        foreach (tbl[i]) step(tbl[i].iv, tbl[i].ev, tbl[i].name);

        // Abort on the third RUN cycle, then a clean full run
        step(4'b0000, {4'h1, 6'b001000}, "ab_pat0");
        step(4'b0000, {4'h3, 6'b001000}, "ab_pat1");
        step(4'b0000, {4'h7, 6'b001000}, "ab_pat2");
        step(4'b0100, {4'h0, 6'b000000}, "ab_to_idle");
        step(4'b0000, {4'h0, 6'b000000}, "ab_idle_stay");
        run_seq(1'b0, 1'b0, "clean");

        // Reset during the first SETTLE cycle
        step(4'b1000, {4'h0, 6'b111000}, "rs_init");
        for (int i = 0; i < 4; i++)
            step(4'b0000, {exp_pat[i], 6'b001000}, $sformatf("rs_pat%0d", i));
        step(4'b0000, {4'h0, 6'b001000}, "rs_settle1");
        step(4'b0010, {4'h0, 6'b000000}, "rs_reset");
        check("rs_lfsr_seed", dut_a.r_lfsr, 16'hACE1);
        step(4'b0000, {4'h0, 6'b000000}, "rs_idle");

        // start held high across a whole run: one DONE cycle then INIT again
        run_seq(1'b1, 1'b0, "held");
        step(4'b1000, {4'h0, 6'b111000}, "held_restart");
        step(4'b0100, {4'h0, 6'b000000}, "held_abort_init");

        // Integrated chain, two back-to-back runs
        ref_sig = model_sig(NPAT_B);
        run_chain(sig1, lat1);
        check("chain1_done", {15'd0, done_b}, 16'd1);
        check("chain1_latency", 16'(lat1), 16'(NPAT_B + 4));
        check("chain1_sig", sig1, ref_sig);
        check("chain1_verdict", {14'd0, pass_b, fail_b},
              {14'd0, (ref_sig == 16'h0000), (ref_sig != 16'h0000)});
        run_chain(sig2, lat2);
        check("chain2_done", {15'd0, done_b}, 16'd1);
        check("chain2_latency", 16'(lat2), 16'(NPAT_B + 4));
        check("chain2_sig", sig2, ref_sig);
        check("chain_repeat", sig2, sig1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
